serial_subtractor: RTL and testbench

// - Bit-serial, multi-cycle subtractor: computes diff = x - y - b_in, one bit per clock, LSB first.
// - Counterpart to the combinational full-adder datapath: the subtract direction, built sequentially.
// - One full-subtractor cell plus shift registers; trades WIDTH cycles of latency for minimal logic.
// - Sits behind an ALU sequencer that issues start and waits for done.
//

---
 rtl/serial_subtractor_pkg.sv | 9 +
 rtl/serial_subtractor_full_subtractor.sv | 11 +
 rtl/serial_subtractor.sv | 75 +++++++
 tb/tb_serial_subtractor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encoding and default operand width.
package serial_subtractor_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit combinational cell computing a - b - b_in.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);
    assign d     = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial x - y - b_in, LSB first, one full-subtractor cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state, next;
    logic [WIDTH-1:0] x_sr, y_sr, d_nx;
    logic [WIDTH-2:0] d_sr;
    logic [CW-1:0] cnt;
    logic brw, x_sign, y_sign, d, bo, load, last;

    full_subtractor u_fs (.a(x_sr[0]), .b(y_sr[0]), .b_in(brw), .d(d), .b_out(bo));

    always_comb begin
        load = start && state != RUN;
        last = state == RUN && cnt == LAST;
        busy = state == RUN;
        done = state == DONE;
        d_nx = {d, d_sr};
        next = load ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;

    // Result registers only move on the final RUN edge so they stay stable during a run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_sr   <= '0;
            y_sr   <= '0;
            d_sr   <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            x_sign <= 1'b0;
            y_sign <= 1'b0;
            diff   <= '0;
            b_out  <= 1'b0;
            ovf    <= 1'b0;
        end else if (load) begin
            x_sr   <= x;
            y_sr   <= y;
            brw    <= b_in;
            cnt    <= '0;
            x_sign <= x[WIDTH-1];
            y_sign <= y[WIDTH-1];
        end else if (busy) begin
            x_sr <= x_sr >> 1;
            y_sr <= y_sr >> 1;
            d_sr <= d_nx[WIDTH-1:1];
            brw  <= bo;
            cnt  <= cnt + CW'(1);
            if (last) begin
                diff  <= d_nx;
                b_out <= bo;
                ovf   <= (x_sign ^ y_sign) & (d ^ x_sign);
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed table, corner sequences, random 8-bit and exhaustive 4-bit checks.
module tb_serial_subtractor;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start8 = 1'b0, b8 = 1'b0, busy8, done8, b_out8, ovf8;
    logic [7:0] x8 = '0, y8 = '0, diff8;
    logic start4 = 1'b0, b4 = 1'b0, busy4, done4, b_out4, ovf4;
    logic [3:0] x4 = '0, y4 = '0, diff4;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .x(x8), .y(y8), .b_in(b8),
        .busy(busy8), .done(done8), .diff(diff8), .b_out(b_out8), .ovf(ovf8)
    );
    serial_subtractor #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4), .b_in(b4),
        .busy(busy4), .done(done4), .diff(diff4), .b_out(b_out4), .ovf(ovf4)
    );

    typedef struct {
        int x, y, b, d, bo, o;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Golden: {b_out, diff} << 1 | ovf, from plain signed/unsigned integer arithmetic.
    function automatic int golden(input int a, input int b, input int bi, input int w);
        int r  = a - b - bi;
        int sa = a >= (1 << (w - 1)) ? a - (1 << w) : a;
        int sb = b >= (1 << (w - 1)) ? b - (1 << w) : b;
        int sr = sa - sb - bi;
        int o  = (sr < -(1 << (w - 1)) || sr >= (1 << (w - 1))) ? 1 : 0;
        return ((r < 0 ? 1 : 0) << (w + 1)) | ((r & ((1 << w) - 1)) << 1) | o;
    endfunction

    task automatic op8(input int a, input int b, input int bi, input int ed, input int ebo,
                       input int eo, input bit lat);
        int cyc = 1, busy_n = 0;
        @(negedge clk);
        x8 = 8'(a); y8 = 8'(b); b8 = 1'(bi); start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); b8 = 1'($urandom);
        while (!done8 && cyc < 30) begin
            if (busy8) busy_n++;
            @(negedge clk);
            cyc++;
        end
        chk("done8_seen", int'(done8), 1);
        chk("diff8", int'(diff8), ed);
        chk("b_out8", int'(b_out8), ebo);
        chk("ovf8", int'(ovf8), eo);
        if (lat) begin
            chk("latency_edges", cyc - 1, 8);
            chk("busy_cycles", busy_n, 8);
            chk("busy_in_done", int'(busy8), 0);
            @(negedge clk);
            chk("done_one_cycle", int'(done8), 0);
            chk("diff8_hold", int'(diff8), ed);
        end
    endtask

    task automatic op4(input int a, input int b, input int bi);
        int cyc = 0, e;
        @(negedge clk);
        x4 = 4'(a); y4 = 4'(b); b4 = 1'(bi); start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; x4 = 4'($urandom); y4 = 4'($urandom); b4 = 1'($urandom);
        while (!done4 && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        e = golden(a, b, bi, 4);
        if (!done4) chk("done4_timeout", 0, 1);
        else begin
            chk("sub4", int'({b_out4, diff4}), e >> 1);
            chk("ovf4", int'(ovf4), e & 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int first, second, cyc, e, seen;
        tbl[0] = '{100, 37, 0, 8'd63, 0, 0};
        tbl[1] = '{5, 10, 0, 8'hFB, 1, 0};
        tbl[2] = '{8'h80, 8'h01, 0, 8'h7F, 0, 1};
        tbl[3] = '{8'h7F, 8'hFF, 0, 8'h80, 1, 1};
        tbl[4] = '{0, 0, 1, 8'hFF, 1, 0};
        tbl[5] = '{8'h80, 8'h7F, 1, 8'h00, 0, 1};

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy8), 0);
        chk("rst_done", int'(done8), 0);
        chk("rst_diff", int'(diff8), 0);
        chk("rst_b_out", int'(b_out8), 0);
        chk("rst_ovf", int'(ovf8), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) op8(tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].d, tbl[i].bo, tbl[i].o, 1'b1);

        // Abort mid-run: outputs from the previous op (ovf=1) must clear immediately.
        @(negedge clk);
        x8 = 8'd100; y8 = 8'd37; b8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_before_rst", int'(busy8), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy8), 0);
        chk("arst_done", int'(done8), 0);
        chk("arst_diff", int'(diff8), 0);
        chk("arst_b_out", int'(b_out8), 0);
        chk("arst_ovf", int'(ovf8), 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8) seen++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done8) seen++;
        end
        chk("no_done_after_abort", seen, 0);
        op8(100, 37, 0, 63, 0, 0, 1'b1);

        // start held high throughout: RUN ignores it, DONE reloads for a back-to-back op.
        @(negedge clk);
        x8 = 8'd100; y8 = 8'd37; b8 = 1'b0; start8 = 1'b1;
        first = -1; second = -1; cyc = 0;
        while (second < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done8 && first < 0) begin
                first = cyc;
                chk("b2b_first_diff", int'(diff8), 63);
                x8 = 8'd5; y8 = 8'd10; b8 = 1'b0;
            end else if (done8) begin
                second = cyc;
                start8 = 1'b0;
                chk("b2b_second_diff", int'(diff8), 8'hFB);
                chk("b2b_second_b_out", int'(b_out8), 1);
            end else if (busy8) begin
                x8 = 8'($urandom); y8 = 8'($urandom); b8 = 1'($urandom);
            end
        end
        chk("b2b_done_spacing", second - first, 9);
        chk("b2b_first_latency", first, 9);
        start8 = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            int a = int'($urandom_range(0, 255)), b = int'($urandom_range(0, 255));
            int bi = int'($urandom_range(0, 1));
            e = golden(a, b, bi, 8);
            op8(a, b, bi, (e >> 1) & 255, (e >> 9) & 1, e & 1, 1'b0);
        end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bi = 0; bi < 2; bi++)
                    op4(a, b, bi);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
